// File: rtl/otter_mmio_pkg.sv
// Purpose: shared register map, CTRL/STATUS bit positions and CTRL layout for the OTTER MMIO responder.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package otter_mmio_pkg;

  // Byte offsets within the decoded 256-byte window
  localparam logic [7:0] OFF_SW     = 8'h00;
  localparam logic [7:0] OFF_BTN    = 8'h04;
  localparam logic [7:0] OFF_LED    = 8'h20;
  localparam logic [7:0] OFF_SSEG   = 8'h40;
  localparam logic [7:0] OFF_CTRL   = 8'h60;
  localparam logic [7:0] OFF_COUNT  = 8'h64;
  localparam logic [7:0] OFF_CMP    = 8'h68;
  localparam logic [7:0] OFF_STATUS = 8'h6C;

  // CTRL bit positions
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_TIE  = 2;
  localparam int CTRL_BIE  = 3;

  // STATUS bit positions
  localparam int STATUS_TPEND = 0;
  localparam int STATUS_BPEND = 1;

  // CTRL register; packed so that en lands on bit 0
  typedef struct packed {
    logic bie;
    logic tie;
    logic auto_rld;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/otter_mmio_responder_if.sv
// Purpose: memory-block <-> IO responder bus (address, strobes, write data, read data).
// Latency: n/a (wires only); read data is combinational in the responder.
// Backpressure: none; every access completes in the cycle it is presented.
// Modports: master = memory block (drives IO_ADDR/IO_WR/IO_RD/IO_DIN), slave = responder (drives IO_IN).
interface otter_mmio_responder_if;
  logic [31:0] IO_ADDR;
  logic        IO_WR;
  logic        IO_RD;
  logic [31:0] IO_DIN;
  logic [31:0] IO_IN;

  modport master (output IO_ADDR, output IO_WR, output IO_RD, output IO_DIN, input IO_IN);
  modport slave  (input IO_ADDR, input IO_WR, input IO_RD, input IO_DIN, output IO_IN);
endinterface

// File: rtl/otter_mmio_timer.sv
// Purpose: prescaled 32-bit timer with compare, one-shot or auto-reload on match.
// Latency: match/en_clr are combinational from registered state; COUNT/CMP writes visible next cycle.
// Backpressure: none; a COUNT write always wins over a same-cycle tick update.
// Ports: clk/rst, en/auto_rld from CTRL, count_wr/cmp_wr + wdata from the decoder,
//        count/cmp readback, match pulse (tick with COUNT==CMP), en_clr (one-shot stop request).
module otter_mmio_timer #(
  parameter int unsigned PRESCALE = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        auto_rld,
  input  logic        count_wr,
  input  logic        cmp_wr,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] cmp,
  output logic        match,
  output logic        en_clr
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;
  logic          tick;

  assign tick   = en && (presc == PRESC_LAST);
  assign match  = tick && (count == cmp);
  assign en_clr = match && !auto_rld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      count <= '0;
      cmp   <= '0;
    end else begin
      // A COUNT load restarts the prescale period so the first tick is a full period away
      if (count_wr) begin
        presc <= '0;
      end else if (en) begin
        presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
      end

      if (cmp_wr) begin
        cmp <= wdata;
      end

      if (count_wr) begin
        count <= wdata;
      end else if (match) begin
        // One-shot holds COUNT at the match value; auto-reload restarts from 0
        if (auto_rld) count <= '0;
      end else if (tick) begin
        count <= count + 32'd1;
      end
    end
  end

endmodule

// File: rtl/otter_mmio_responder.sv
// Purpose: OTTER MMIO responder: decode, switch/button inputs, LED/7-seg regs, timer, STATUS and IRQ.
// Latency: reads are combinational (zero cycles); writes commit on the next CLK rising edge; IRQ is registered.
// Backpressure: none; every access completes in its own cycle.
// Ports: CLK/RST (async active-high), bus (slave modport: IO_ADDR/IO_WR/IO_RD/IO_DIN in, IO_IN out),
//        SWITCHES/BUTTONS raw async inputs, LEDS/SSEG_VAL register outputs, IRQ level interrupt.
// Build option: define OTTER_MMIO_DEBOUNCE_EN to debounce each synced button over DEBOUNCE_CYC samples.
module otter_mmio_responder
  import otter_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1100_0000,
  parameter int unsigned SW_W         = 16,
  parameter int unsigned BTN_W        = 5,
  parameter int unsigned PRESCALE     = 100,
  parameter int unsigned DEBOUNCE_CYC = 500_000
) (
  input  logic                   CLK,
  input  logic                   RST,
  otter_mmio_responder_if.slave  bus,
  input  logic [SW_W-1:0]        SWITCHES,
  input  logic [BTN_W-1:0]       BUTTONS,
  output logic [15:0]            LEDS,
  output logic [15:0]            SSEG_VAL,
  output logic                   IRQ
);

  // ---------------- decode ----------------
  logic       hit;
  logic [7:0] offset;
  logic       wr_hit;

  assign hit    = (bus.IO_ADDR[31:8] == BASE_ADDR[31:8]) && (bus.IO_ADDR[1:0] == 2'b00);
  assign offset = bus.IO_ADDR[7:0];
  assign wr_hit = bus.IO_WR && hit;

  // Reads carry no side effects, so the read enable has nothing to qualify
  logic unused_rd;
  assign unused_rd = bus.IO_RD;

  // ---------------- input synchronizers ----------------
  logic [SW_W-1:0]  sw_s1, sw_s2;
  logic [BTN_W-1:0] btn_s1, btn_s2;
  logic [BTN_W-1:0] btn_val;
  logic [BTN_W-1:0] btn_prev;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= SWITCHES;
      sw_s2  <= sw_s1;
      btn_s1 <= BUTTONS;
      btn_s2 <= btn_s1;
    end
  end

`ifdef OTTER_MMIO_DEBOUNCE_EN
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);
  logic [DB_W-1:0]  db_cnt [BTN_W];
  logic [BTN_W-1:0] btn_db;

  // Counts consecutive samples that differ from the debounced level; the level
  // flips only once DEBOUNCE_CYC of them arrive in a row.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      btn_db <= '0;
      for (int i = 0; i < int'(BTN_W); i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(BTN_W); i++) begin
        if (btn_s2[i] == btn_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
          btn_db[i] <= btn_s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign btn_val = btn_db;
`else
  assign btn_val = btn_s2;
`endif

  logic btn_rise;
  assign btn_rise = |(btn_val & ~btn_prev);

  // ---------------- timer ----------------
  ctrl_t       ctrl;
  logic [31:0] count, cmp;
  logic        tmr_match, tmr_en_clr;

  otter_mmio_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .en       (ctrl.en),
    .auto_rld (ctrl.auto_rld),
    .count_wr (wr_hit && (offset == OFF_COUNT)),
    .cmp_wr   (wr_hit && (offset == OFF_CMP)),
    .wdata    (bus.IO_DIN),
    .count    (count),
    .cmp      (cmp),
    .match    (tmr_match),
    .en_clr   (tmr_en_clr)
  );

  // ---------------- registers ----------------
  logic tpend, bpend;
  logic w1c;

  assign w1c = wr_hit && (offset == OFF_STATUS);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      LEDS     <= '0;
      SSEG_VAL <= '0;
      ctrl     <= '0;
      tpend    <= 1'b0;
      bpend    <= 1'b0;
      btn_prev <= '0;
      IRQ      <= 1'b0;
    end else begin
      btn_prev <= btn_val;

      if (wr_hit && (offset == OFF_LED))  LEDS     <= bus.IO_DIN[15:0];
      if (wr_hit && (offset == OFF_SSEG)) SSEG_VAL <= bus.IO_DIN[15:0];

      // Software CTRL write overrides the timer's one-shot stop
      if (wr_hit && (offset == OFF_CTRL)) ctrl <= ctrl_t'(bus.IO_DIN[3:0]);
      else if (tmr_en_clr)                ctrl.en <= 1'b0;

      // Hardware set wins over a same-cycle write-1-to-clear
      if (tmr_match)                            tpend <= 1'b1;
      else if (w1c && bus.IO_DIN[STATUS_TPEND]) tpend <= 1'b0;

      if (btn_rise)                             bpend <= 1'b1;
      else if (w1c && bus.IO_DIN[STATUS_BPEND]) bpend <= 1'b0;

      IRQ <= (tpend && ctrl.tie) || (bpend && ctrl.bie);
    end
  end

  // ---------------- read mux ----------------
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (offset)
        OFF_SW:     rdata = 32'(sw_s2);
        OFF_BTN:    rdata = 32'(btn_val);
        OFF_LED:    rdata = {16'h0, LEDS};
        OFF_SSEG:   rdata = {16'h0, SSEG_VAL};
        OFF_CTRL:   rdata = {28'h0, ctrl};
        OFF_COUNT:  rdata = count;
        OFF_CMP:    rdata = cmp;
        OFF_STATUS: rdata = {30'h0, bpend, tpend};
        default:    rdata = '0;
      endcase
    end
  end

  assign bus.IO_IN = rdata;

endmodule

// File: tb/tb_otter_mmio_responder.sv
// Purpose: self-checking bench for otter_mmio_responder: register-map vector table, hand-written
//          timer/button/reset sequences and a randomized register-access run against a reference model.
// Latency/backpressure: the bench drives at the falling edge and samples 1 time unit after the rising edge.
module tb_otter_mmio_responder;

  localparam logic [31:0] BASE = 32'h1100_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] SWITCHES = '0;
  logic [4:0]  BUTTONS  = '0;
  logic [15:0] LEDS;
  logic [15:0] SSEG_VAL;
  logic        IRQ;

  otter_mmio_responder_if bus ();

  otter_mmio_responder #(
    .BASE_ADDR    (BASE),
    .SW_W         (16),
    .BTN_W        (5),
    .PRESCALE     (4),
    .DEBOUNCE_CYC (8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus.slave),
    .SWITCHES (SWITCHES),
    .BUTTONS  (BUTTONS),
    .LEDS     (LEDS),
    .SSEG_VAL (SSEG_VAL),
    .IRQ      (IRQ)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    bus.IO_ADDR = a;
    bus.IO_DIN  = d;
    bus.IO_WR   = 1'b1;
    @(posedge CLK);
    #1 bus.IO_WR = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.IO_ADDR = a;
    bus.IO_RD   = 1'b1;
    #1 d = bus.IO_IN;
    bus.IO_RD   = 1'b0;
  endtask

  // ---------------- reference model of the register map ----------------
  logic [31:0] m_led, m_sseg, m_ctrl, m_count, m_cmp, m_sw;

  function automatic bit m_hit(input logic [31:0] a);
    return ((a >> 8) == (BASE >> 8)) && ((a % 4) == 0);
  endfunction

  function automatic void m_write(input logic [31:0] a, input logic [31:0] d);
    if (!m_hit(a)) return;
    case (a & 32'hFF)
      32'h20: m_led   = d & 32'hFFFF;
      32'h40: m_sseg  = d & 32'hFFFF;
      32'h60: m_ctrl  = d & 32'hF;
      32'h64: m_count = d;
      32'h68: m_cmp   = d;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_hit(a)) return 32'h0;
    case (a & 32'hFF)
      32'h00:  return m_sw;
      32'h20:  return m_led;
      32'h40:  return m_sseg;
      32'h60:  return m_ctrl;
      32'h64:  return m_count;
      32'h68:  return m_cmp;
      default: return 32'h0;  // buttons idle, STATUS clear, unmapped offsets
    endcase
  endfunction

  // ---------------- register-map vector table ----------------
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [15:0] exp_leds;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] offs [9];

    vecs[0] = '{1'b1, 32'h1100_0020, 32'h0000_A5A5, 32'h0000_A5A5, 16'hA5A5};
    vecs[1] = '{1'b1, 32'h1100_0021, 32'h0000_FFFF, 32'h0000_0000, 16'hA5A5};
    vecs[2] = '{1'b1, 32'h1100_0100, 32'h0000_1234, 32'h0000_0000, 16'hA5A5};
    vecs[3] = '{1'b1, 32'h1100_0020, 32'hDEAD_0F0F, 32'h0000_0F0F, 16'h0F0F};
    vecs[4] = '{1'b1, 32'h1100_0000, 32'h0000_FFFF, 32'h0000_0000, 16'h0F0F};

    bus.IO_ADDR = '0;
    bus.IO_DIN  = '0;
    bus.IO_WR   = 1'b0;
    bus.IO_RD   = 1'b0;

    // ---- reset ----
    repeat (3) @(posedge CLK);
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;
    bus_read(32'h1100_0020, rd); check("rst_led_rd", rd, 32'h0);
    bus_read(32'h1100_006C, rd); check("rst_status_rd", rd, 32'h0);
    check("rst_leds", 32'(LEDS), 32'h0);
    check("rst_irq", 32'(IRQ), 32'h0);

    // ---- table ----
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      bus_read(vecs[i].addr, rd);
      check($sformatf("tbl%0d_rd", i), rd, vecs[i].exp_rd);
      check($sformatf("tbl%0d_leds", i), 32'(LEDS), 32'(vecs[i].exp_leds));
    end

    // ---- switch synchronizer: visible within three edges, not after one ----
    @(negedge CLK) SWITCHES = 16'h1234;
    bus_read(32'h1100_0000, rd); check("sw_edge0", rd, 32'h0);
    @(posedge CLK); #1;
    bus_read(32'h1100_0000, rd); check("sw_edge1", rd, 32'h0);
    repeat (2) @(posedge CLK); #1;
    bus_read(32'h1100_0000, rd); check("sw_edge3", rd, 32'h1234);

    // ---- one-shot timer: PRESCALE=4, CMP=3 -> match 16 cycles after enable ----
    bus_write(32'h1100_0064, 32'h0);
    bus_write(32'h1100_0068, 32'h3);
    bus_write(32'h1100_0060, 32'h5);          // EN | TIE
    repeat (15) @(posedge CLK); #1;
    bus_read(32'h1100_006C, rd); check("os_tpend_early", rd, 32'h0);
    @(posedge CLK); #1;
    bus_read(32'h1100_006C, rd); check("os_tpend_set", rd, 32'h1);
    check("os_irq_lag", 32'(IRQ), 32'h0);
    bus_read(32'h1100_0060, rd); check("os_en_cleared", rd, 32'h4);
    bus_read(32'h1100_0064, rd); check("os_count_hold", rd, 32'h3);
    @(posedge CLK); #1;
    check("os_irq_set", 32'(IRQ), 32'h1);
    bus_write(32'h1100_006C, 32'h1);
    bus_read(32'h1100_006C, rd); check("os_w1c", rd, 32'h0);
    check("os_irq_lag_clr", 32'(IRQ), 32'h1);
    @(posedge CLK); #1;
    check("os_irq_clr", 32'(IRQ), 32'h0);

    // ---- auto-reload with W1C landing on the match edge ----
    bus_write(32'h1100_0064, 32'h0);
    bus_write(32'h1100_0068, 32'h2);
    bus_write(32'h1100_0060, 32'h7);          // EN | AUTO | TIE
    repeat (11) @(posedge CLK); #1;
    bus_write(32'h1100_006C, 32'h1);          // commits on the 12th edge = match
    bus_read(32'h1100_006C, rd); check("ar_tpend_kept", rd, 32'h1);
    bus_read(32'h1100_0064, rd); check("ar_count_zero", rd, 32'h0);
    bus_read(32'h1100_0060, rd); check("ar_en_kept", rd, 32'h7);
    @(posedge CLK); #1;
    check("ar_irq", 32'(IRQ), 32'h1);
    bus_write(32'h1100_0060, 32'h0);
    bus_write(32'h1100_006C, 32'h1);

    // ---- button edge -> BPEND -> IRQ ----
    bus_write(32'h1100_0060, 32'h8);          // BIE
    @(posedge CLK); #1;
    check("btn_irq_idle", 32'(IRQ), 32'h0);
`ifdef OTTER_MMIO_DEBOUNCE_EN
    @(negedge CLK) BUTTONS = 5'b00001;
    repeat (5) @(negedge CLK);
    BUTTONS = 5'b00000;
    repeat (15) @(posedge CLK); #1;
    bus_read(32'h1100_006C, rd); check("db_short_pulse", rd, 32'h0);
    @(negedge CLK) BUTTONS = 5'b00001;
    repeat (12) @(negedge CLK);
    BUTTONS = 5'b00000;
    repeat (15) @(posedge CLK); #1;
    bus_read(32'h1100_006C, rd); check("db_long_pulse", rd, 32'h2);
    check("db_irq", 32'(IRQ), 32'h1);
`else
    @(negedge CLK) BUTTONS = 5'b00001;
    repeat (2) @(posedge CLK); #1;
    bus_read(32'h1100_0004, rd); check("btn_readback", rd, 32'h1);
    @(posedge CLK);
    @(negedge CLK) BUTTONS = 5'b00000;
    repeat (3) @(posedge CLK); #1;
    bus_read(32'h1100_006C, rd); check("btn_bpend", rd, 32'h2);
    check("btn_irq", 32'(IRQ), 32'h1);
`endif

    // ---- asynchronous reset mid-operation ----
    bus_write(32'h1100_0060, 32'hD);          // timer running, BIE, TIE
    @(posedge CLK); #1;
    RST = 1'b1;
    #2;
    check("mid_rst_leds", 32'(LEDS), 32'h0);
    check("mid_rst_irq", 32'(IRQ), 32'h0);
    bus_read(32'h1100_0060, rd); check("mid_rst_ctrl", rd, 32'h0);
    bus_read(32'h1100_006C, rd); check("mid_rst_status", rd, 32'h0);
    @(negedge CLK) RST = 1'b0;

    // ---- randomized register accesses against the model ----
    SWITCHES = 16'hBEEF;
    m_led = 0; m_sseg = 0; m_ctrl = 0; m_count = 0; m_cmp = 0; m_sw = 32'hBEEF;
    repeat (3) @(posedge CLK); #1;
    offs = '{32'h00, 32'h04, 32'h20, 32'h40, 32'h60, 32'h64, 32'h68, 32'h6C, 32'h10};
    for (int it = 0; it < 40; it++) begin
      logic [31:0] a, b, d;
      a = BASE + offs[$urandom_range(0, 8)];
      if ($urandom_range(0, 5) == 0) a = a + $urandom_range(1, 3);
      if ($urandom_range(0, 5) == 0) a = a ^ (32'h100 << $urandom_range(0, 23));
      d = $urandom;
      if ((a & 32'hFF) == 32'h60) d = d & ~32'h1;   // keep the timer frozen
      bus_write(a, d);
      m_write(a, d);
      bus_read(a, rd); check($sformatf("rnd%0d_rd_a", it), rd, m_read(a));
      b = BASE + offs[$urandom_range(0, 8)];
      bus_read(b, rd); check($sformatf("rnd%0d_rd_b", it), rd, m_read(b));
      check($sformatf("rnd%0d_leds", it), 32'(LEDS), m_led);
      check($sformatf("rnd%0d_sseg", it), 32'(SSEG_VAL), m_sseg);
    end
    @(posedge CLK); #1;
    check("rnd_irq_quiet", 32'(IRQ), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
